// File: rtl/ps2_note_encoder_if.sv
// Byte-in / note-out bundle for the PS/2 note encoder.
// The master drives scan bytes and the slave returns registered note events.
interface ps2_note_encoder_if;
    logic       byte_valid;
    logic [7:0] byte_in;
    logic       note_in;
    logic [3:0] note;
    logic [2:0] octave;
    logic       note_held;

    modport master (
        output byte_valid, byte_in,
        input  note_in, note, octave, note_held
    );

    modport slave (
        input  byte_valid, byte_in,
        output note_in, note, octave, note_held
    );
endinterface

// File: rtl/ps2_note_encoder.sv
// Decodes PS/2 set-2 make/break sequences into a monophonic note stream.
// Uses last-note priority, typematic suppression and a saturating octave selector.
module ps2_note_encoder #(
    parameter logic [2:0] DEFAULT_OCTAVE = 3'd4
) (
    input  logic              clk,
    input  logic              reset,
    ps2_note_encoder_if.slave bus
);

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_GOT_F0   = 2'd1,
        S_GOT_E0   = 2'd2,
        S_GOT_E0F0 = 2'd3
    } state_t;

    localparam logic [7:0] K_BREAK = 8'hF0;
    localparam logic [7:0] K_EXT   = 8'hE0;
    localparam logic [7:0] K_HI_C  = 8'h42;
    localparam logic [7:0] K_OCT_D = 8'h1A;
    localparam logic [7:0] K_OCT_U = 8'h22;

    // Returns {hit, note index} for the twelve base keys.
    function automatic logic [4:0] key_map(input logic [7:0] code);
        logic [4:0] m;
        m = 5'd0;
        case (code)
            8'h1C: m = {1'b1, 4'd0};
            8'h1D: m = {1'b1, 4'd1};
            8'h1B: m = {1'b1, 4'd2};
            8'h24: m = {1'b1, 4'd3};
            8'h23: m = {1'b1, 4'd4};
            8'h2B: m = {1'b1, 4'd5};
            8'h2C: m = {1'b1, 4'd6};
            8'h34: m = {1'b1, 4'd7};
            8'h35: m = {1'b1, 4'd8};
            8'h33: m = {1'b1, 4'd9};
            8'h3C: m = {1'b1, 4'd10};
            8'h3B: m = {1'b1, 4'd11};
            default: m = 5'd0;
        endcase
        return m;
    endfunction

    state_t     r_state;
    state_t     w_state_next;
    logic       r_vld_p0;
    logic [7:0] r_byte_p0;
    logic       w_make;
    logic       w_break;

    logic       r_note_in;
    logic [3:0] r_note;
    logic [2:0] r_octave;
    logic       r_note_held;
    logic [7:0] r_held_code;
    logic [2:0] r_cur_oct;

    logic [4:0] w_map;
    logic       w_is_hi;
    logic       w_note_hit;
    logic [2:0] w_note_oct;
    logic       w_trigger;
    logic       w_release;

    // Stage p0: capture the incoming byte.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_vld_p0  <= 1'b0;
            r_byte_p0 <= 8'h00;
        end else begin
            r_vld_p0  <= bus.byte_valid;
            r_byte_p0 <= bus.byte_in;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        if (r_vld_p0) begin
            case (r_state)
                S_IDLE: begin
                    if (r_byte_p0 == K_BREAK)    w_state_next = S_GOT_F0;
                    else if (r_byte_p0 == K_EXT) w_state_next = S_GOT_E0;
                end
                S_GOT_F0:   w_state_next = S_IDLE;
                S_GOT_E0:   w_state_next = (r_byte_p0 == K_BREAK) ? S_GOT_E0F0 : S_IDLE;
                S_GOT_E0F0: w_state_next = S_IDLE;
                default:    w_state_next = S_IDLE;
            endcase
        end
    end

    always_comb begin
        w_make  = 1'b0;
        w_break = 1'b0;
        if (r_vld_p0) begin
            w_make  = (r_state == S_IDLE) && (r_byte_p0 != K_BREAK) && (r_byte_p0 != K_EXT);
            w_break = (r_state == S_GOT_F0);
        end
    end

    // Key 42 is the high C; it is dropped when no octave remains above cur_oct.
    always_comb begin
        w_map      = key_map(r_byte_p0);
        w_is_hi    = (r_byte_p0 == K_HI_C);
        w_note_hit = w_map[4] || (w_is_hi && (r_cur_oct != 3'd7));
        w_note_oct = w_is_hi ? (r_cur_oct + 3'd1) : r_cur_oct;
        w_trigger  = w_make && w_note_hit && (!r_note_held || (r_byte_p0 != r_held_code));
        w_release  = w_break && r_note_held && (r_byte_p0 == r_held_code);
    end

    // Stage p1: registered note outputs and octave selector.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_note_in   <= 1'b0;
            r_note      <= 4'd0;
            r_octave    <= DEFAULT_OCTAVE;
            r_note_held <= 1'b0;
            r_held_code <= 8'h00;
            r_cur_oct   <= DEFAULT_OCTAVE;
        end else begin
            r_note_in <= w_trigger;
            if (w_trigger) begin
                r_note      <= w_map[3:0];
                r_octave    <= w_note_oct;
                r_held_code <= r_byte_p0;
                r_note_held <= 1'b1;
            end else if (w_release) begin
                r_note_held <= 1'b0;
            end
            if (w_make && (r_byte_p0 == K_OCT_D) && (r_cur_oct != 3'd0))
                r_cur_oct <= r_cur_oct - 3'd1;
            else if (w_make && (r_byte_p0 == K_OCT_U) && (r_cur_oct != 3'd7))
                r_cur_oct <= r_cur_oct + 3'd1;
        end
    end

    assign bus.note_in   = r_note_in;
    assign bus.note      = r_note;
    assign bus.octave    = r_octave;
    assign bus.note_held = r_note_held;

endmodule

// File: tb/tb_ps2_note_encoder.sv
// Directed scan-byte sequences with a queue-based scoreboard of note_in pulses.
module tb_ps2_note_encoder;

    logic clk;
    logic reset;
    int   cyc;
    int   n_cmp;
    int   n_fail;

    typedef struct {
        logic [3:0] note;
        logic [2:0] oct;
        int         cyc;
    } exp_t;

    exp_t q[$];
    exp_t e;

    ps2_note_encoder_if bus ();

    ps2_note_encoder #(.DEFAULT_OCTAVE(3'd4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: every pulse must match the head of the queue at its stamped cycle.
    always @(negedge clk) begin
        while (q.size() > 0 && q[0].cyc < cyc) begin
            e = q.pop_front();
            n_cmp++;
            n_fail++;
            $display("FAIL missing_pulse: got no pulse at cycle %0d, required note=%0d octave=%0d", e.cyc, e.note, e.oct);
        end
        if (!reset && bus.note_in) begin
            n_cmp++;
            if (q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_pulse: got note=%0d octave=%0d at cycle %0d, required no pulse", bus.note, bus.octave, cyc);
            end else begin
                e = q.pop_front();
                if (bus.note !== e.note || bus.octave !== e.oct || bus.note_held !== 1'b1 || cyc != e.cyc) begin
                    n_fail++;
                    $display("FAIL pulse: got note=%0d octave=%0d held=%0d cycle=%0d, required note=%0d octave=%0d held=1 cycle=%0d",
                             bus.note, bus.octave, bus.note_held, cyc, e.note, e.oct, e.cyc);
                end
            end
        end
    end

    task automatic send(input logic [7:0] b);
        bus.byte_valid = 1'b1;
        bus.byte_in    = b;
        @(negedge clk);
        bus.byte_valid = 1'b0;
    endtask

    task automatic sendx(input logic [7:0] b, input logic [3:0] n, input logic [2:0] o);
        exp_t x;
        x.note = n;
        x.oct  = o;
        x.cyc  = cyc + 2;
        q.push_back(x);
        send(b);
    endtask

    task automatic chk(input string name, input int act, input int exp_v);
        n_cmp++;
        if (act != exp_v) begin
            n_fail++;
            $display("FAIL %s: got %0d, required %0d", name, act, exp_v);
        end
    endtask

    task automatic settle();
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        n_cmp  = 0;
        n_fail = 0;
        reset  = 1'b1;
        bus.byte_valid = 1'b0;
        bus.byte_in    = 8'h00;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        settle();

        chk("rst_note_in", int'(bus.note_in), 0);
        chk("rst_note", int'(bus.note), 0);
        chk("rst_octave", int'(bus.octave), 4);
        chk("rst_held", int'(bus.note_held), 0);

        // Single press and release.
        sendx(8'h1C, 4'd0, 3'd4); settle();
        chk("press_held", int'(bus.note_held), 1);
        send(8'hF0); send(8'h1C); settle();
        chk("release_held", int'(bus.note_held), 0);
        chk("release_note", int'(bus.note), 0);
        chk("release_octave", int'(bus.octave), 4);

        // Typematic repeats produce one pulse.
        sendx(8'h1C, 4'd0, 3'd4); send(8'h1C); send(8'h1C); settle();
        chk("repeat_held", int'(bus.note_held), 1);
        send(8'hF0); send(8'h1C); settle();

        // Last-note priority; releasing the older key keeps the note held.
        sendx(8'h1C, 4'd0, 3'd4); sendx(8'h33, 4'd9, 3'd4); settle();
        send(8'hF0); send(8'h1C); settle();
        chk("old_release_held", int'(bus.note_held), 1);
        send(8'hF0); send(8'h33); settle();
        chk("new_release_held", int'(bus.note_held), 0);
        chk("new_release_note", int'(bus.note), 9);

        // Octave up saturates at 7, high C is then dropped.
        repeat (5) send(8'h22);
        send(8'h42); settle();
        chk("oct_keys_keep_output", int'(bus.octave), 4);
        send(8'h1A);
        sendx(8'h42, 4'd0, 3'd7); settle();
        chk("hi_c_octave", int'(bus.octave), 7);
        send(8'hF0); send(8'h42); settle();

        // Extended sequences never touch outputs; cur_oct is now 6.
        send(8'hE0); send(8'h1C); send(8'hE0); send(8'hF0); send(8'h1C);
        sendx(8'h1D, 4'd1, 3'd6); settle();
        chk("ext_then_note", int'(bus.note), 1);

        // Back-to-back bytes, pulses on consecutive cycles; unrelated break ignored.
        sendx(8'h2B, 4'd5, 3'd6); sendx(8'h24, 4'd3, 3'd6); settle();
        send(8'hF0); send(8'h2B); settle();
        chk("other_break_held", int'(bus.note_held), 1);
        send(8'hF0); send(8'h24); settle();
        chk("burst_release_held", int'(bus.note_held), 0);
        send(8'h15); settle();

        // Octave down saturates at 0.
        repeat (8) send(8'h1A);
        sendx(8'h1C, 4'd0, 3'd0); settle();
        send(8'hF0); send(8'h1C);
        send(8'h22); send(8'h22);
        sendx(8'h42, 4'd0, 3'd3); settle();
        send(8'hF0); send(8'h42); settle();

        // Reset in the middle of a break sequence.
        send(8'hF0); settle();
        reset = 1'b1;
        settle();
        reset = 1'b0;
        chk("midrst_held", int'(bus.note_held), 0);
        chk("midrst_octave", int'(bus.octave), 4);
        chk("midrst_note", int'(bus.note), 0);
        sendx(8'h1C, 4'd0, 3'd4); settle();
        chk("post_rst_held", int'(bus.note_held), 1);

        repeat (4) settle();
        chk("queue_drained", q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/ps2_note_encoder.md
PS2_NOTE_ENCODER -- requirements
Module: ps2_note_encoder

Interface
REQ-001 Parameter DEFAULT_OCTAVE, default 4: octave value loaded at reset.
REQ-002 clk  input  1  system clock, all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 byte_valid  input  1  one-cycle strobe; byte_in holds a received PS/2 set-2 scan byte.
REQ-005 byte_in  input  8  scan byte, sampled only when byte_valid=1.
REQ-006 note_in  output  1  one-cycle pulse; a new note is presented on note/octave.
REQ-007 note  output  4  note index, 0=C, 1=C#, ... 11=B.
REQ-008 octave  output  3  octave of the presented note, 0..7.
REQ-009 note_held  output  1  high while the presented note's key is held.

Function
REQ-010 Decoder FSM states SHALL be IDLE, GOT_F0, GOT_E0, GOT_E0F0, advancing only on byte_valid.
REQ-011 IDLE: byte F0 -> GOT_F0; byte E0 -> GOT_E0; any other byte is processed as a make code and the FSM stays in IDLE.
REQ-012 GOT_F0: the next byte is processed as a break code, then the FSM returns to IDLE.
REQ-013 GOT_E0: byte F0 -> GOT_E0F0; any other byte is discarded and the FSM returns to IDLE.
REQ-014 GOT_E0F0: the next byte is discarded and the FSM returns to IDLE; extended keys never affect outputs.
REQ-015 Key map (hex): 1C=0, 1D=1, 1B=2, 24=3, 23=4, 2B=5, 2C=6, 34=7, 35=8, 33=9, 3C=10, 3B=11.
REQ-016 Key 42 SHALL map to note 0 at the current octave + 1.
REQ-017 Key 1A SHALL be octave-down and key 22 SHALL be octave-up, both saturating at 0 and 7.
REQ-018 An internal octave register cur_oct SHALL hold the octave; octave keys change only cur_oct, not the octave output.
REQ-019 Make code of a note key whose code differs from the held code, or any note key when note_held=0, SHALL register note and octave, register the held code, set note_held=1, and pulse note_in.
REQ-020 Latency: byte sampled at edge N -> note, octave, note_held and note_in SHALL be valid after edge N+1; note_in stays high exactly one cycle.
REQ-021 Make code equal to the currently held code (typematic repeat) SHALL be ignored, with no note_in pulse.
REQ-022 A new note key while another is held SHALL retrigger the output (last-note priority) with a note_in pulse.
REQ-023 Break code equal to the held code SHALL clear note_held on the next edge; note and octave SHALL hold their values.
REQ-024 Break of any other code, and make of an unmapped code, SHALL be ignored.
REQ-025 Key 42 with cur_oct=7 SHALL be ignored entirely.
REQ-026 A change of cur_oct SHALL not retrigger a held note; it applies from the next note make.
REQ-027 byte_valid on consecutive cycles SHALL be handled byte by byte, with no byte lost.
REQ-028 note_in pulses on consecutive cycles are permitted.
REQ-029 All outputs SHALL be registered.

Reset
REQ-030 Reset SHALL asynchronously set the FSM to IDLE, note_in=0, note=0, note_held=0, held code=00, and octave=cur_oct=DEFAULT_OCTAVE.
REQ-031 Reset asserted mid-sequence (for example, after F0) SHALL discard the partial sequence.
REQ-032 After reset release, the next byte SHALL be decoded from IDLE.

Verification
REQ-033 Bytes 1C, F0, 1C after reset -> note_in pulse with note=0, octave=4, note_held=1; after the break, note_held=0 and note stays 0.
REQ-034 Bytes 1C, 1C, 1C -> exactly one note_in pulse.
REQ-035 Bytes 1C, 33 -> two pulses; second pulse shows note=9. Then F0 1C -> note_held remains 1. Then F0 33 -> note_held=0.
REQ-036 Bytes 22 x5, then 42 -> cur_oct saturates at 7 and 42 gives no pulse. Then 1A, 42 -> pulse with note=0, octave=7.
REQ-037 Bytes E0, 1C, E0, F0, 1C, then 1D -> no pulse for the extended bytes; 1D gives a pulse with note=1.
REQ-038 Bytes F0, reset pulse, 1C -> pulse with note=0, octave=4 (1C treated as make).
